// File: rtl/xor_delay_scheduler.sv
// Delays a^b^c by a programmable number of cycles through a small in-order event queue.
// Supports transport delivery (every event) and inertial delivery (a new change cancels pending events).
module xor_delay_scheduler #(
    parameter int DELAY = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a,
    input  logic                         b,
    input  logic                         c,
    input  logic                         mode,
    output logic                         out,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         busy,
    output logic                         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]              tcnt;
    logic [2:0]                    abc_q;
    logic [DEPTH-1:0][CNT_W-1:0]   due_mem;
    logic [DEPTH-1:0]              val_mem;
    logic [PW-1:0]                 head;
    logic [PW-1:0]                 tail;
    logic [CW-1:0]                 count;

    logic                          ev;
    logic                          ev_v;
    logic [CNT_W-1:0]              ev_due;
    logic                          pop;
    logic                          full;
    logic                          push;
    logic                          drop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        ev     = ({a, b, c} != abc_q);
        ev_v   = a ^ b ^ c;
        ev_due = tcnt + CNT_W'(DELAY);
        pop    = (count != '0) && (due_mem[head] == tcnt);
        full   = (count == CW'(DEPTH));
        push   = ev && !mode && (!full || pop);
        drop   = ev && !mode && full && !pop;
    end

    // An inertial event rebuilds the queue as a single entry; the maturing head is still delivered first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            abc_q    <= '0;
            out      <= 1'b0;
            overflow <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            due_mem  <= '0;
            val_mem  <= '0;
        end else begin
            tcnt  <= tcnt + CNT_W'(1);
            abc_q <= {a, b, c};
            if (pop)
                out <= val_mem[head];
            if (ev && mode) begin
                due_mem[0] <= ev_due;
                val_mem[0] <= ev_v;
                head       <= '0;
                tail       <= nxt('0);
                count      <= CW'(1);
            end else begin
                if (pop)
                    head <= nxt(head);
                if (push) begin
                    due_mem[tail] <= ev_due;
                    val_mem[tail] <= ev_v;
                    tail          <= nxt(tail);
                end
                count <= count + CW'(push) - CW'(pop);
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    assign pending = count;
    assign busy    = (count != '0);

endmodule

// File: tb/tb_xor_delay_scheduler.sv
// Directed bench for xor_delay_scheduler: transport, inertial, overflow, full push/pop,
// counter wrap-around (narrow instance) and asynchronous reset.
module tb_xor_delay_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, mode = 1'b0;
    logic       out, busy, overflow;
    logic [2:0] pending;
    logic       a2 = 1'b0;
    logic       out2, busy2, overflow2;
    logic [2:0] pending2;

    int nCompared = 0;
    int nMismatched = 0;

    xor_delay_scheduler #(.DELAY(6), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .mode(mode),
        .out(out), .pending(pending), .busy(busy), .overflow(overflow)
    );

    xor_delay_scheduler #(.DELAY(6), .DEPTH(4), .CNT_W(4)) dutWrap (
        .clk(clk), .rst_n(rst_n), .a(a2), .b(1'b0), .c(1'b0), .mode(1'b0),
        .out(out2), .pending(pending2), .busy(busy2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        nCompared++;
        if (got != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] abc);
        {a, b, c} = abc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds reset across a full cycle, checks the cleared outputs, releases at a falling edge.
    task automatic doReset(input logic m);
        mode = m;
        applyStimulus(3'b000);
        a2 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset out", out, 0);
        checkOutput("reset pending", pending, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int expOut(input logic m, input int e);
        if (!m) return ((e >= 18 && e <= 20) || e >= 28) ? 1 : 0;
        return (e >= 28) ? 1 : 0;
    endfunction

    function automatic int expPend(input logic m, input int e);
        if (e < 12) return 0;
        if (!m) begin
            if (e < 15) return 1;
            if (e < 18) return 2;
            if (e < 21) return 1;
        end else if (e < 21) return 1;
        if (e == 21) return 0;
        if (e < 28) return 1;
        return 0;
    endfunction

    task automatic runBasic(input logic m);
        string nm;
        nm = m ? "inr" : "trn";
        doReset(m);
        for (int e = 1; e <= 30; e++) begin
            if (e == 10) applyStimulus(3'b000);
            if (e == 12) applyStimulus(3'b100);
            if (e == 15) applyStimulus(3'b011);
            if (e == 22) applyStimulus(3'b111);
            tick();
            checkOutput($sformatf("%s out e%0d", nm, e), out, expOut(m, e));
            checkOutput($sformatf("%s pending e%0d", nm, e), pending, expPend(m, e));
        end
        checkOutput({nm, " busy end"}, busy, 0);
        checkOutput({nm, " overflow end"}, overflow, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        runBasic(1'b0);
        runBasic(1'b1);

        // Five consecutive changes into a 4-deep queue: fifth is dropped.
        doReset(1'b0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            applyStimulus({~a, 2'b00});
            tick();
        end
        checkOutput("ovf pending", pending, 4);
        checkOutput("ovf flag", overflow, 1);
        tick();
        checkOutput("ovf out pre", out, 0);
        checkOutput("ovf pending pre", pending, 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("ovf out d%0d", i), out, (i % 2 == 0) ? 1 : 0);
            checkOutput($sformatf("ovf pending d%0d", i), pending, 3 - i);
        end
        checkOutput("ovf sticky", overflow, 1);

        // Full queue, head matures on the same edge as a new change.
        doReset(1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus({~a, 2'b00});
            tick();
        end
        checkOutput("pp full", pending, 4);
        tick(); tick();
        applyStimulus(3'b100);
        tick();
        checkOutput("pp out", out, 1);
        checkOutput("pp pending", pending, 4);
        checkOutput("pp overflow", overflow, 0);
        tick();
        checkOutput("pp out next", out, 0);
        checkOutput("pp pending next", pending, 3);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("pp last out", out, 1);
        checkOutput("pp drained", busy, 0);

        // Narrow counter: change sampled at tcnt=13 matures at tcnt=3.
        doReset(1'b0);
        for (int e = 1; e <= 20; e++) begin
            if (e == 14) a2 = 1'b1;
            tick();
            if (e == 14) checkOutput("wrap pending", pending2, 1);
            if (e == 19) checkOutput("wrap out early", out2, 0);
            if (e == 20) begin
                checkOutput("wrap out", out2, 1);
                checkOutput("wrap pending end", pending2, 0);
            end
        end

        // Asynchronous reset with three events queued.
        doReset(1'b0);
        applyStimulus(3'b100);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("ar out set", out, 1);
        applyStimulus(3'b000); tick();
        applyStimulus(3'b100); tick();
        applyStimulus(3'b000); tick();
        checkOutput("ar pending 3", pending, 3);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("ar out", out, 0);
        checkOutput("ar pending", pending, 0);
        checkOutput("ar busy", busy, 0);
        checkOutput("ar overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("ar quiet out %0d", i), out, 0);
        end
        checkOutput("ar quiet pending", pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
